// File: rtl/add_accum_if.sv
// Handshake bundle between add_accum, its operand source, its result consumer and the
// external four-bit adder (a/b out, sum back in).
interface add_accum_if #(
    parameter int unsigned LEN_W = 4
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [3:0]       in_data;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       sum;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       result;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, sum, out_ready,
        input  in_ready, a, b, out_valid, result, ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, sum, out_ready,
        output in_ready, a, b, out_valid, result, ovf, busy
    );
endinterface

// File: rtl/add_accum.sv
// Sequenced accumulator: sums LEN operands through an external adder, flags carry-out.
// Build option: define ADD_ACCUM_SATURATE_EN to clamp the accumulator at 4'hF on carry.
module add_accum #(
    parameter int unsigned LEN_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    add_accum_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             beat;
    logic             carry;
    logic [3:0]       acc_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= 4'h0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign beat  = (state_q == StAccum) && bus.in_valid;
    // The adder wraps mod 16, so a smaller sum means bit 3 carried out.
    assign carry = beat && (bus.sum < acc_q);

`ifdef ADD_ACCUM_SATURATE_EN
    assign acc_beat = carry ? 4'hF : bus.sum;
`else
    assign acc_beat = bus.sum;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (beat && (cnt_q == LEN_W'(1))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == StIdle && bus.start) begin
            acc_d = 4'h0;
            ovf_d = 1'b0;
            cnt_d = bus.len;
        end else if (beat) begin
            acc_d = acc_beat;
            cnt_d = cnt_q - LEN_W'(1);
            ovf_d = ovf_q | carry;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StAccum);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.a         = acc_q;
        bus.b         = (state_q == StAccum) ? bus.in_data : 4'h0;
        bus.result    = acc_q;
        bus.ovf       = ovf_q;
    end
endmodule

// File: tb/tb_add_accum.sv
// Directed bench for add_accum: vector table plus reset-abort sequences; models the adder.
module tb_add_accum;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    add_accum_if #(.LEN_W(4)) bus ();

    add_accum #(.LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.sum = bus.a + bus.b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       len;
        logic [15:0][3:0] ops;
        logic [3:0]       gap;
        logic [3:0]       hold;
        logic             poke;
        logic [3:0]       res_wrap;
        logic [3:0]       res_sat;
        logic             ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, int'(bus.in_ready), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_a"}, int'(bus.a), 0);
        check({tag, "_b"}, int'(bus.b), 0);
        check({tag, "_result"}, int'(bus.result), 0);
        check({tag, "_ovf"}, int'(bus.ovf), 0);
    endtask

    function automatic vec_t mk(input logic [3:0] len, input logic [3:0] o0, input logic [3:0] o1,
                                input logic [3:0] o2, input logic [3:0] o3, input logic [3:0] gap,
                                input logic [3:0] hold, input logic poke, input logic [3:0] rw,
                                input logic [3:0] rs, input logic ovf);
        vec_t v;
        v          = '0;
        v.len      = len;
        v.ops[0]   = o0;
        v.ops[1]   = o1;
        v.ops[2]   = o2;
        v.ops[3]   = o3;
        v.gap      = gap;
        v.hold     = hold;
        v.poke     = poke;
        v.res_wrap = rw;
        v.res_sat  = rs;
        v.ovf      = ovf;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] acc_m;
        logic [4:0] s;
        logic [3:0] exp_res;
`ifdef ADD_ACCUM_SATURATE_EN
        exp_res = v.res_sat;
`else
        exp_res = v.res_wrap;
`endif
        acc_m        = 4'h0;
        bus.start    = 1'b1;
        bus.len      = v.len;
        bus.in_valid = (v.len == 4'd0);
        bus.in_data  = 4'd9;
        tick();
        bus.start = 1'b0;
        if (v.len == 4'd0) begin
            check($sformatf("v%0d_len0_done", idx), int'(bus.out_valid), 1);
        end else begin
            check($sformatf("v%0d_accum_ready", idx), int'(bus.in_ready), 1);
            check($sformatf("v%0d_accum_nvalid", idx), int'(bus.out_valid), 0);
            check($sformatf("v%0d_acc_cleared", idx), int'(bus.a), 0);
        end
        for (int i = 0; i < int'(v.len); i++) begin
            for (int g = 0; g < int'(v.gap); g++) begin
                bus.in_valid = 1'b0;
                bus.start    = v.poke && (g == 0);
                tick();
                bus.start = 1'b0;
                check($sformatf("v%0d_gap_hold", idx), int'(bus.a), int'(acc_m));
            end
            bus.in_valid = 1'b1;
            bus.in_data  = v.ops[i];
            tick();
            bus.in_valid = 1'b0;
            s = {1'b0, acc_m} + {1'b0, v.ops[i]};
`ifdef ADD_ACCUM_SATURATE_EN
            acc_m = s[4] ? 4'hF : s[3:0];
`else
            acc_m = s[3:0];
`endif
            check($sformatf("v%0d_beat%0d_valid", idx, i), int'(bus.out_valid),
                  (i == int'(v.len) - 1) ? 1 : 0);
        end
        check($sformatf("v%0d_result", idx), int'(bus.result), int'(exp_res));
        check($sformatf("v%0d_ovf", idx), int'(bus.ovf), int'(v.ovf));
        check($sformatf("v%0d_done_nready", idx), int'(bus.in_ready), 0);
        for (int h = 0; h < int'(v.hold); h++) begin
            bus.out_ready = 1'b0;
            bus.start     = v.poke && (h == 1);
            tick();
            bus.start = 1'b0;
            check($sformatf("v%0d_hold_valid", idx), int'(bus.out_valid), 1);
            check($sformatf("v%0d_hold_result", idx), int'(bus.result), int'(exp_res));
            check($sformatf("v%0d_hold_ovf", idx), int'(bus.ovf), int'(v.ovf));
        end
        bus.out_ready = 1'b1;
        bus.start     = v.poke;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        check($sformatf("v%0d_idle_valid", idx), int'(bus.out_valid), 0);
        check($sformatf("v%0d_idle_busy", idx), int'(bus.busy), 0);
        tick();
        check($sformatf("v%0d_stay_idle", idx), int'(bus.busy), 0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.out_ready = 1'b0;

        vecs[0] = mk(4'd3, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd1, 1'b0, 4'd6, 4'd6, 1'b0);
        vecs[1] = mk(4'd2, 4'hF, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 4'd0, 4'hF, 1'b1);
        vecs[2] = mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 1'b0, 4'd0, 4'd0, 1'b0);
        vecs[3] = mk(4'd2, 4'd5, 4'd9, 4'd0, 4'd0, 4'd3, 4'd5, 1'b1, 4'd14, 4'd14, 1'b0);
        vecs[4] = mk(4'd4, 4'd8, 4'd8, 4'd3, 4'd0, 4'd1, 4'd1, 1'b0, 4'd3, 4'hF, 1'b1);
        vecs[5] = mk(4'd1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd1, 4'd3, 1'b1, 4'd7, 4'd7, 1'b0);
        vecs[6] = mk(4'd15, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 1'b0, 4'd15, 4'd15, 1'b0);
        for (int i = 4; i < 15; i++) vecs[6].ops[i] = 4'd1;

        #1;
        check_zero("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Abort mid-accumulation: outputs drop without a clock edge.
        bus.start    = 1'b1;
        bus.len      = 4'd3;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd3;
        tick();
        check("rst_acc_pre", int'(bus.a), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_accum");
        tick();
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rst_accum_no_result", int'(bus.out_valid), 0);
            check("rst_accum_idle", int'(bus.busy), 0);
        end

        // Abort while a result is pending.
        bus.start = 1'b1;
        bus.len   = 4'd1;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd5;
        tick();
        bus.in_valid = 1'b0;
        check("rst_done_pre", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_done");
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_done_no_result", int'(bus.out_valid), 0);
        end
        bus.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
